// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: controller state codes, framing constants and CRC-32 helpers shared by the TX path
package eth_tx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PREAMBLE  = 4'd1,
        ST_SFD       = 4'd2,
        ST_DEST_ADDR = 4'd3,
        ST_SRC_ADDR  = 4'd4,
        ST_LEN_TYPE  = 4'd5,
        ST_DATA      = 4'd6,
        ST_PAD       = 4'd7,
        ST_FCS       = 4'd8
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam int          FCS_DIBITS    = 16;

    // one reflected CRC step for a single serial bit
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        return (c >> 1) ^ ((c[0] ^ b) ? CRC_POLY : 32'h0);
    endfunction

    // byte i of a 48-bit MAC, byte 0 being bits 47:40
    function automatic logic [7:0] mac_byte(input logic [47:0] v, input logic [4:0] i);
        return 8'((v << {i, 3'b000}) >> 40);
    endfunction

endpackage

// File: rtl/eth_crc32_d2.sv
// eth_crc32_d2: combinational reflected CRC-32 next state for one dibit, bit 0 first
module eth_crc32_d2
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  d,
    output logic [31:0] crc_out
);

    assign crc_out = crc_bit(crc_bit(crc_in, d[0]), d[1]);

endmodule

// File: rtl/eth_tx_dibit.sv
// eth_tx_dibit: RMII dibit transmit datapath driven by the TX controller state; ETH_TX_IFG_EN adds an inter-frame gap on Tx_Ready
module eth_tx_dibit
    import eth_tx_pkg::*;
#(
    parameter logic [47:0] pDest_Addr  = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] pSrc_Addr   = 48'h02_00_00_00_00_01,
    parameter logic [15:0] pLen_Type   = 16'h0800,
    parameter int          pIfg_Cycles = 48
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [3:0]  Tx_Ctrl_FSM_State,
    input  logic        Crc_En,
    input  logic [7:0]  Fifo_Data,
    input  logic        Fifo_Valid,
    output logic [1:0]  Txd,
    output logic        Tx_En,
    output logic        Tx_Ready,
    output logic        Frame_Done,
    output logic        Underrun,
    output logic [15:0] Frame_Cnt
);

    localparam int GW = $clog2(pIfg_Cycles + 1);

    logic [3:0]    st, state_q;
    logic [6:0]    dcnt_q, dc;
    logic [4:0]    idx;
    logic [1:0]    dib, txd_d;
    logic [31:0]   crc_q, crc_nx, crc_d;
    logic [7:0]    buf_q, data_q, data_byte, cur_byte;
    logic          full_q, xfer, tx_en_d, crc_upd, done_d;
    logic [GW-1:0] gap_q;

    assign st = Tx_Ctrl_FSM_State;

    eth_crc32_d2 u_crc (
        .crc_in (crc_q),
        .d      (txd_d),
        .crc_out(crc_nx)
    );

    // next dibit, CRC and payload transfer from the controller state and dibit position
    always_comb begin
        dc        = (st != state_q) ? 7'd0 : dcnt_q + 7'd1;
        idx       = dc[6:2];
        dib       = dc[1:0];
        xfer      = (st == ST_DATA) && (dib == 2'd0);
        data_byte = xfer ? (full_q ? buf_q : 8'h00) : data_q;
        cur_byte  = (st == ST_PREAMBLE)  ? PREAMBLE_BYTE :
                    (st == ST_SFD)       ? SFD_BYTE :
                    (st == ST_DEST_ADDR) ? mac_byte(pDest_Addr, idx) :
                    (st == ST_SRC_ADDR)  ? mac_byte(pSrc_Addr, idx) :
                    (st == ST_LEN_TYPE)  ? ((idx == 5'd0) ? pLen_Type[15:8] : pLen_Type[7:0]) :
                    (st == ST_DATA)      ? data_byte : 8'h00;
        tx_en_d   = (st >= ST_PREAMBLE) && (st <= ST_FCS);
        txd_d     = !tx_en_d ? 2'b00 : (st == ST_FCS) ? ~crc_q[1:0] : cur_byte[{dib, 1'b0} +: 2];
        crc_upd   = Crc_En && (st >= ST_DEST_ADDR) && (st <= ST_PAD);
        crc_d     = (st == ST_IDLE) ? CRC_INIT : (st == ST_FCS) ? (crc_q >> 2) : crc_upd ? crc_nx : crc_q;
        done_d    = (st == ST_FCS) && (dc == 7'(FCS_DIBITS - 1));
    end

    // output, CRC, dibit counter and payload buffer registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            dcnt_q     <= '0;
            crc_q      <= CRC_INIT;
            Txd        <= 2'b00;
            Tx_En      <= 1'b0;
            Frame_Done <= 1'b0;
            Frame_Cnt  <= '0;
            Underrun   <= 1'b0;
            buf_q      <= '0;
            full_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= st;
            dcnt_q     <= dc;
            crc_q      <= crc_d;
            Txd        <= txd_d;
            Tx_En      <= tx_en_d;
            Frame_Done <= done_d;
            Frame_Cnt  <= Frame_Cnt + {15'd0, done_d};
            full_q     <= Fifo_Valid || (full_q && !xfer);
            if (Fifo_Valid)
                buf_q <= Fifo_Data;
            if (xfer)
                data_q <= data_byte;
            if ((st == ST_PREAMBLE) && (state_q != ST_PREAMBLE))
                Underrun <= 1'b0;
            else if (xfer && !full_q)
                Underrun <= 1'b1;
        end
    end

`ifdef ETH_TX_IFG_EN
    // gap counter loaded when the controller returns from FCS to IDLE
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            gap_q <= '0;
        else if ((state_q == ST_FCS) && (st == ST_IDLE))
            gap_q <= GW'(pIfg_Cycles);
        else if (gap_q != '0)
            gap_q <= gap_q - GW'(1);
    end
`else
    assign gap_q = '0;
`endif

    assign Tx_Ready = (state_q == ST_IDLE) && (gap_q == '0);

endmodule
